// File: rtl/rowbias_pkg.sv
// Shared types and helpers for the per-row value-bias shuffle pools.
package rowbias_pkg;

  // Widest row the lookup helper can handle.
  localparam int MAX_LEN = 64;

  // One-hot controller states.
  typedef enum logic [4:0] {
    ST_RESET    = 5'b00001,
    ST_SWAP_0   = 5'b00010,
    ST_SWAP_1   = 5'b00100,
    ST_NEXT_ROW = 5'b01000,
    ST_READY    = 5'b10000
  } state_e;

  // INIT walks every row once after reset, SINGLE re-shuffles one requested row.
  typedef enum logic {
    MODE_INIT   = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_e;

  // Number of values (and pool entries) per row for a given grid order.
  function automatic int len_of(input int ord);
    return ord * ord;
  endfunction

  // Keeps only the lowest set bit, so a multi-hot index resolves deterministically.
  function automatic logic [MAX_LEN-1:0] lowest_onehot(input logic [MAX_LEN-1:0] vec);
    return vec & (~vec + MAX_LEN'(1));
  endfunction

endpackage

// File: rtl/lfsr.sv
// Galois right-shift lfsr with synchronous seed load and advance enable.
module lfsr #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  logic [WIDTH-1:0] state_q, state_d;

  // Load wins over advance; otherwise shift right and fold the taps in when a one drops out.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (adv_i) begin
      state_d = state_q[0] ? ((state_q >> 1) ^ TAPS) : (state_q >> 1);
    end
  end

  // State register, cleared on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= '0;
    else        state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/rowbias_lookup.sv
// Registered per-row lookup: picks the pool entry selected by the lowest set index bit.
module rowbias_lookup
  import rowbias_pkg::*;
#(
  parameter int LEN = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    freeze_i,
  input  logic [LEN-1:0]          index_i,
  input  logic [LEN-1:0][LEN-1:0] pool_i,
  output logic [LEN-1:0]          val_o,
  output logic                    valid_o
);

  logic [LEN-1:0] sel;
  logic [LEN-1:0] picked;
  logic [LEN-1:0] val_q, val_d;
  logic           valid_q, valid_d;

  // Frozen rows hold their value but drop valid; a zero index holds both.
  always_comb begin
    sel    = LEN'(lowest_onehot(MAX_LEN'(index_i)));
    picked = '0;
    for (int k = 0; k < LEN; k++) begin
      if (sel[k]) picked = picked | pool_i[k];
    end
    val_d   = val_q;
    valid_d = valid_q;
    if (freeze_i) begin
      valid_d = 1'b0;
    end else if (|index_i) begin
      val_d   = picked;
      valid_d = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      val_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      valid_q <= valid_d;
    end
  end

  assign val_o   = val_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/rowbias_pool.sv
// NUM_ROWS independent shuffle pools, each an inside-out Fisher-Yates permutation of
// the LEN one-hot values, with single-row re-shuffle and per-row registered lookup.
// Optional macro ROWBIAS_POOL_PERMCHECK_EN adds a sticky perm_error output.
module rowbias_pool
  import rowbias_pkg::*;
#(
  parameter int                    ORD        = 2,
  parameter int                    NUM_ROWS   = ORD * ORD,
  parameter int                    LFSR_WIDTH = 16,
  parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS  = LFSR_WIDTH'(16'hB400),
  parameter int                    ROW_W      = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int                   LEN        = len_of(ORD)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [LFSR_WIDTH-1:0]        seed,
  output logic                         ready,
  input  logic                         shuffle_req,
  input  logic [ROW_W-1:0]             shuffle_row,
  output logic                         shuffle_busy,
  input  logic [NUM_ROWS-1:0][LEN-1:0] index,
  output logic [NUM_ROWS-1:0][LEN-1:0] valtotry,
  output logic [NUM_ROWS-1:0]          valtotry_valid
`ifdef ROWBIAS_POOL_PERMCHECK_EN
  ,
  output logic                         perm_error
`endif
);

  localparam int SEL_W  = $clog2(LEN);
  localparam int IDX_W  = $clog2(LEN + 1);
  localparam int RSEL_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  state_e                              state_q, state_d;
  mode_e                               mode_q, mode_d;
  logic [IDX_W-1:0]                    i_q, i_d, j_q, j_d;
  logic [ROW_W-1:0]                    row_q, row_d;
  logic [LEN-1:0]                      temp_q, temp_d;
  logic [NUM_ROWS-1:0][LEN-1:0][LEN-1:0] pool_q, pool_d;
  logic                                ready_q, ready_d, busy_q, busy_d;
  logic                                lfsr_load, lfsr_adv;
  logic [LFSR_WIDTH-1:0]               lfsr_q;
  logic                                accept, last_swap;
  logic [SEL_W-1:0]                    i_sel, j_sel;
  logic [RSEL_W-1:0]                   row_sel;

  assign i_sel     = i_q[SEL_W-1:0];
  assign j_sel     = j_q[SEL_W-1:0];
  assign row_sel   = row_q[RSEL_W-1:0];
  assign last_swap = (i_q + IDX_W'(1)) == IDX_W'(LEN);
  assign accept    = (state_q == ST_READY) && shuffle_req && !busy_q &&
                     (32'(shuffle_row) < 32'(NUM_ROWS));

  lfsr #(
    .WIDTH (LFSR_WIDTH),
    .TAPS  (LFSR_TAPS)
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .seed_i  (seed),
    .state_o (lfsr_q)
  );

  // Controller state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RESET;
    else        state_q <= state_d;
  end

  // Controller next-state: two swap cycles per element, one bookkeeping cycle per row.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RESET:    state_d = ST_SWAP_0;
      ST_SWAP_0:   state_d = ST_SWAP_1;
      ST_SWAP_1:   state_d = last_swap ? ST_NEXT_ROW : ST_SWAP_0;
      ST_NEXT_ROW: state_d = ((mode_q == MODE_SINGLE) || (row_q == ROW_W'(NUM_ROWS - 1)))
                             ? ST_READY : ST_SWAP_0;
      ST_READY:    state_d = accept ? ST_SWAP_0 : ST_READY;
      default:     state_d = ST_RESET;
    endcase
  end

  // Controller outputs: the seed is taken in RESET and randomness is consumed only while swapping.
  always_comb begin
    lfsr_load = (state_q == ST_RESET);
    lfsr_adv  = (state_q == ST_SWAP_0) || (state_q == ST_SWAP_1);
  end

  // Shuffle datapath: inside-out Fisher-Yates, j for the next element drawn during this swap.
  always_comb begin
    i_d     = i_q;
    j_d     = j_q;
    row_d   = row_q;
    mode_d  = mode_q;
    temp_d  = temp_q;
    pool_d  = pool_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      ST_RESET: begin
        i_d    = '0;
        j_d    = '0;
        row_d  = '0;
        mode_d = MODE_INIT;
      end
      ST_SWAP_0: begin
        if (i_q != j_q) temp_d = pool_q[row_sel][j_sel];
      end
      ST_SWAP_1: begin
        if (i_q != j_q) pool_d[row_sel][i_sel] = temp_q;
        pool_d[row_sel][j_sel] = LEN'(1) << i_q;
        j_d = IDX_W'(lfsr_q % (LFSR_WIDTH'(i_q) + LFSR_WIDTH'(2)));
        i_d = i_q + IDX_W'(1);
      end
      ST_NEXT_ROW: begin
        i_d = '0;
        j_d = '0;
        if (mode_q == MODE_INIT) begin
          if (row_q == ROW_W'(NUM_ROWS - 1)) ready_d = 1'b1;
          else                               row_d   = row_q + ROW_W'(1);
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_READY: begin
        if (accept) begin
          row_d  = shuffle_row;
          mode_d = MODE_SINGLE;
          busy_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers, all cleared on reset so an aborted shuffle restarts cleanly.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_q     <= '0;
      j_q     <= '0;
      row_q   <= '0;
      mode_q  <= MODE_INIT;
      temp_q  <= '0;
      pool_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      i_q     <= i_d;
      j_q     <= j_d;
      row_q   <= row_d;
      mode_q  <= mode_d;
      temp_q  <= temp_d;
      pool_q  <= pool_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign ready        = ready_q;
  assign shuffle_busy = busy_q;

  // A row is frozen from the edge its shuffle is accepted until the edge busy drops.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic freeze;
    assign freeze = !ready_q || (busy_q && (row_q == ROW_W'(r))) ||
                    (accept && (shuffle_row == ROW_W'(r)));
    rowbias_lookup #(
      .LEN (LEN)
    ) u_lookup (
      .clock    (clock),
      .reset    (reset),
      .freeze_i (freeze),
      .index_i  (index[r]),
      .pool_i   (pool_q[r]),
      .val_o    (valtotry[r]),
      .valid_o  (valtotry_valid[r])
    );
  end

`ifdef ROWBIAS_POOL_PERMCHECK_EN
  logic           perm_ok, perm_chk, perm_error_q;
  logic [LEN-1:0] perm_acc;

  // A finished row must cover every value exactly once: full OR and one bit per entry.
  always_comb begin
    perm_ok  = 1'b1;
    perm_acc = '0;
    perm_chk = (state_q == ST_SWAP_1) && (state_d == ST_NEXT_ROW);
    for (int k = 0; k < LEN; k++) begin
      perm_acc = perm_acc | pool_d[row_sel][k];
      if ($countones(pool_d[row_sel][k]) != 1) perm_ok = 1'b0;
    end
    if (perm_acc != '1) perm_ok = 1'b0;
  end

  // Sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                   perm_error_q <= 1'b0;
    else if (perm_chk && !perm_ok) perm_error_q <= 1'b1;
  end

  assign perm_error = perm_error_q;

`ifndef SYNTHESIS
  // Flag a broken permutation the moment a row finishes.
  always @(posedge clock) begin
    if (reset && perm_chk) assert (perm_ok);
  end
`endif
`endif

endmodule

// File: tb/tb_rowbias_pool.sv
// Directed bench for rowbias_pool at ORD=2, NUM_ROWS=4 with a bench-side shuffle model.
module tb_rowbias_pool;

  localparam int ORD = 2;
  localparam int LEN = 4;
  localparam int NR  = 4;
  localparam int RW  = 3;

  typedef logic [NR-1:0][LEN-1:0] idxv_t;

  typedef struct {
    idxv_t          idx;
    logic [NR-1:0]  expValid;
  } vec_t;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [15:0]         seed;
  logic                ready;
  logic                shuffle_req;
  logic [RW-1:0]       shuffle_row;
  logic                shuffle_busy;
  idxv_t               index;
  idxv_t               valtotry;
  logic [NR-1:0]       valtotry_valid;
`ifdef ROWBIAS_POOL_PERMCHECK_EN
  logic                perm_error;
`endif

  int compared   = 0;
  int mismatched = 0;

  logic [3:0]  modelPool [NR][LEN];
  logic [15:0] modelLf;
  logic [3:0]  expVal [NR];

  always #5 clock = ~clock;

  rowbias_pool #(
    .ORD        (ORD),
    .NUM_ROWS   (NR),
    .LFSR_WIDTH (16),
    .LFSR_TAPS  (16'hB400),
    .ROW_W      (RW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .seed           (seed),
    .ready          (ready),
    .shuffle_req    (shuffle_req),
    .shuffle_row    (shuffle_row),
    .shuffle_busy   (shuffle_busy),
    .index          (index),
    .valtotry       (valtotry),
    .valtotry_valid (valtotry_valid)
`ifdef ROWBIAS_POOL_PERMCHECK_EN
    ,
    .perm_error     (perm_error)
`endif
  );

  // Galois step of the 16-bit lfsr with taps B400.
  function automatic logic [15:0] lfStep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  // Position of the lowest set bit, -1 when none.
  function automatic int lowBit(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return b;
    return -1;
  endfunction

  // Reference inside-out Fisher-Yates for one row, consuming two lfsr steps per element.
  task automatic modelShuffle(input int r);
    int          j;
    logic [15:0] rnd;
    j = 0;
    for (int i = 0; i < LEN; i++) begin
      modelLf = lfStep(modelLf);
      rnd     = modelLf;
      modelLf = lfStep(modelLf);
      if (i != j) modelPool[r][i] = modelPool[r][j];
      modelPool[r][j] = 4'(1 << i);
      j = int'(rnd % 16'(i + 2));
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive the index vector and let one edge register the lookups.
  task automatic applyStimulus(input idxv_t idx);
    index = idx;
    tick();
  endtask

  // Single comparison with bookkeeping.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Look up every index on every row; check against the model and that each row is a permutation.
  task automatic permScan(input string tag);
    idxv_t      idx;
    logic [3:0] seen [NR];
    logic       ok [NR];
    for (int r = 0; r < NR; r++) begin
      seen[r] = '0;
      ok[r]   = 1'b1;
    end
    for (int k = 0; k < LEN; k++) begin
      for (int r = 0; r < NR; r++) idx[r] = 4'(1 << k);
      applyStimulus(idx);
      for (int r = 0; r < NR; r++) begin
        checkOutput($sformatf("%s_val_r%0d_k%0d", tag, r, k), 32'(valtotry[r]), 32'(modelPool[r][k]));
        if ($countones(valtotry[r]) != 1 || (seen[r] & valtotry[r]) != 4'h0) ok[r] = 1'b0;
        seen[r]   = seen[r] | valtotry[r];
        expVal[r] = modelPool[r][k];
      end
    end
    for (int r = 0; r < NR; r++)
      checkOutput($sformatf("%s_perm_r%0d", tag, r), 32'({ok[r], seen[r]}), 32'h1F);
    checkOutput({tag, "_valid"}, 32'(valtotry_valid), 32'hF);
  endtask

  vec_t tbl [5];

  initial begin
    int    cnt;
    int    cyc;
    idxv_t idx;

    // Lookup vectors, rows packed {r3, r2, r1, r0}, starting from all-invalid outputs.
    tbl[0] = '{idx: {4'b0000, 4'b0100, 4'b0000, 4'b0000}, expValid: 4'b0100};
    tbl[1] = '{idx: {4'b0000, 4'b0000, 4'b0000, 4'b0000}, expValid: 4'b0100};
    tbl[2] = '{idx: {4'b0000, 4'b0000, 4'b1010, 4'b0000}, expValid: 4'b0110};
    tbl[3] = '{idx: {4'b1100, 4'b1000, 4'b0000, 4'b0001}, expValid: 4'b1111};
    tbl[4] = '{idx: {4'b0000, 4'b0011, 4'b0110, 4'b1111}, expValid: 4'b1111};

    seed        = 16'h0001;
    index       = '0;
    shuffle_req = 1'b0;
    shuffle_row = '0;

    // Expected pools after the initial shuffle from this seed.
    modelLf = seed;
    for (int r = 0; r < NR; r++) modelShuffle(r);

    // Held in reset.
    tick();
    tick();
    checkOutput("rst_ready", 32'(ready), 32'h0);
    checkOutput("rst_busy", 32'(shuffle_busy), 32'h0);
    checkOutput("rst_valid", 32'(valtotry_valid), 32'h0);
    checkOutput("rst_val", 32'(valtotry), 32'h0);

    // Release, then abort the initial shuffle at its 20th edge.
    reset = 1'b1;
    for (int e = 0; e < 20; e++) tick();
    reset = 1'b0;
    #1;
    checkOutput("abort_ready", 32'(ready), 32'h0);
    checkOutput("abort_busy", 32'(shuffle_busy), 32'h0);
    checkOutput("abort_valid", 32'(valtotry_valid), 32'h0);
    checkOutput("abort_val", 32'(valtotry), 32'h0);
    tick();
    reset = 1'b1;

    // Ready must rise on the 37th edge after release.
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!ready && cnt < 200);
    checkOutput("ready_latency", 32'(cnt), 32'd37);

    // Table-driven lookups: lowest bit wins, zero index holds value and valid.
    for (int r = 0; r < NR; r++) expVal[r] = 4'h0;
    for (int v = 0; v < 5; v++) begin
      applyStimulus(tbl[v].idx);
      for (int r = 0; r < NR; r++) begin
        if (tbl[v].idx[r] != 4'h0) expVal[r] = modelPool[r][lowBit(tbl[v].idx[r])];
        checkOutput($sformatf("tbl%0d_val_r%0d", v, r), 32'(valtotry[r]), 32'(expVal[r]));
      end
      checkOutput($sformatf("tbl%0d_valid", v), 32'(valtotry_valid), 32'(tbl[v].expValid));
    end

    // Every row is a permutation and matches the model.
    permScan("init");

    // Re-shuffle row 3 while rows 0-2 keep serving; a second request during busy is dropped.
    applyStimulus({4'b0000, 4'b0001, 4'b0001, 4'b0001});
    shuffle_req = 1'b1;
    shuffle_row = 3'd3;
    tick();
    shuffle_req = 1'b0;
    modelShuffle(3);
    cnt = 0;
    cyc = 0;
    while (shuffle_busy && cyc < 30) begin
      cnt++;
      checkOutput($sformatf("busy_valid3_c%0d", cyc), 32'(valtotry_valid[3]), 32'h0);
      for (int r = 0; r < 3; r++) idx[r] = 4'(1 << ((cyc + r) % 4));
      idx[3] = 4'h0;
      if (cyc == 2) begin
        shuffle_req = 1'b1;
        shuffle_row = 3'd0;
      end
      applyStimulus(idx);
      shuffle_req = 1'b0;
      for (int r = 0; r < 3; r++) begin
        checkOutput($sformatf("busy_val_r%0d_c%0d", r, cyc), 32'(valtotry[r]),
                    32'(modelPool[r][(cyc + r) % 4]));
        checkOutput($sformatf("busy_vld_r%0d_c%0d", r, cyc), 32'(valtotry_valid[r]), 32'h1);
      end
      cyc++;
    end
    checkOutput("busy_cycles", 32'(cnt), 32'd9);
    checkOutput("post_valid3", 32'(valtotry_valid[3]), 32'h0);
    applyStimulus({4'b0000, 4'b0001, 4'b0001, 4'b0001});
    checkOutput("post_valid3_hold", 32'(valtotry_valid[3]), 32'h0);
    permScan("resh");

    // Out-of-range row: no busy, pools untouched.
    shuffle_req = 1'b1;
    shuffle_row = 3'd5;
    tick();
    shuffle_req = 1'b0;
    checkOutput("badrow_busy0", 32'(shuffle_busy), 32'h0);
    tick();
    checkOutput("badrow_busy1", 32'(shuffle_busy), 32'h0);
    checkOutput("badrow_ready", 32'(ready), 32'h1);
    permScan("badrow");

`ifdef ROWBIAS_POOL_PERMCHECK_EN
    checkOutput("perm_error", 32'(perm_error), 32'h0);
`endif

    // Asynchronous reset clears nonzero outputs before the next edge.
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_ready", 32'(ready), 32'h0);
    checkOutput("async_valid", 32'(valtotry_valid), 32'h0);
    checkOutput("async_val", 32'(valtotry), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
